move_seq: RTL

MOVE_SEQ -- requirements
Module: move_seq

---
 rtl/move_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/move_seq.sv
// move_seq: square-move sequencer for the heading PID.
// Aligns heading, ramps forward speed, counts stripes, decelerates.
module move_seq #(
    parameter bit          FAST_SIM = 1'b1,
    parameter logic [9:0]  MAX_SPD  = 10'h2A0,
    parameter logic [11:0] ALGN_THR = 12'h02C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_go,
    input  logic [2:0]  num_sq,
    input  logic        heading_rdy,
    input  logic [11:0] error,
    input  logic        cntrIR,
    output logic [9:0]  frwrd,
    output logic        moving,
    output logic        busy,
    output logic        move_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALIGN,
        S_RAMP,
        S_DECEL
    } state_t;

    localparam logic [9:0]  INC = FAST_SIM ? 10'h020 : 10'h004;
    localparam logic [10:0] DEC = {INC, 1'b0};

    state_t      r_state;
    logic [9:0]  r_frwrd;
    logic        r_move_done;
    logic [2:0]  r_num_sq;
    logic [2:0]  r_stripe;
    logic        r_ir_prev;

    logic [12:0] w_err_ext;
    logic [12:0] w_err_abs;
    logic        w_aligned;
    logic [10:0] w_ramp_sum;
    logic [9:0]  w_ramp_nxt;
    logic [9:0]  w_decel_nxt;
    logic        w_ir_rise;
    logic [2:0]  w_stripe_inc;

    // 13-bit magnitude so the most negative error cannot wrap negative
    assign w_err_ext = {error[11], error};
    assign w_err_abs = error[11] ? (13'd0 - w_err_ext) : w_err_ext;
    assign w_aligned = (w_err_abs < {1'b0, ALGN_THR});

    // Saturating speed steps
    assign w_ramp_sum  = {1'b0, r_frwrd} + {1'b0, INC};
    assign w_ramp_nxt  = (w_ramp_sum > {1'b0, MAX_SPD}) ?
                         MAX_SPD : w_ramp_sum[9:0];
    assign w_decel_nxt = ({1'b0, r_frwrd} < DEC) ?
                         10'd0 : (r_frwrd - DEC[9:0]);

    assign w_ir_rise    = cntrIR & ~r_ir_prev;
    assign w_stripe_inc = r_stripe + 3'd1;

    assign frwrd     = r_frwrd;
    assign busy      = (r_state != S_IDLE);
    assign moving    = (r_state != S_IDLE);
    assign move_done = r_move_done;

    // Main sequencer: state, speed, stripe count and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_frwrd     <= 10'd0;
            r_move_done <= 1'b0;
            r_num_sq    <= 3'd0;
            r_stripe    <= 3'd0;
            r_ir_prev   <= 1'b0;
        end else begin
            r_move_done <= 1'b0;
            r_ir_prev   <= cntrIR;
            case (r_state)
                S_IDLE: begin
                    r_frwrd <= 10'd0;
                    if (cmd_go) begin
                        if (num_sq != 3'd0) begin
                            r_num_sq <= num_sq;
                            r_stripe <= 3'd0;
                            r_state  <= S_ALIGN;
                        end else begin
                            r_move_done <= 1'b1;
                        end
                    end
                end
                S_ALIGN: begin
                    if (heading_rdy && w_aligned) begin
                        r_state <= S_RAMP;
                    end
                end
                S_RAMP: begin
                    if (heading_rdy) begin
                        r_frwrd <= w_ramp_nxt;
                    end
                    if (w_ir_rise) begin
                        r_stripe <= w_stripe_inc;
                        if (w_stripe_inc == r_num_sq) begin
                            r_state <= S_DECEL;
                        end
                    end
                end
                S_DECEL: begin
                    if (r_frwrd == 10'd0) begin
                        r_state     <= S_IDLE;
                        r_move_done <= 1'b1;
                    end else if (heading_rdy) begin
                        r_frwrd <= w_decel_nxt;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
